// File: rtl/pipe_en_r.sv
// DEPTH-stage, WIDTH-bit pipeline register chain with per-stage valid bits.
// Supports a global stall, a flush, and rigid (lock-step) or elastic (bubble-collapsing) advance.
module pipe_en_r #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 3,
   parameter int               MODE      = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             d,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             q,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_reg  [DEPTH];
   logic [WIDTH-1:0] data_next [DEPTH];
   logic [WIDTH-1:0] src_data  [DEPTH];
   logic [DEPTH-1:0] valid_reg;
   logic [DEPTH-1:0] valid_next;
   logic [DEPTH-1:0] src_valid;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] load;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;

   // Ready chain runs from the output back to stage 0, purely combinational.
   always_comb begin
      adv = '1;
      if (MODE != 0) begin
         adv[DEPTH-1] = !valid_reg[DEPTH-1] | out_ready;
         for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !valid_reg[i] | adv[i+1];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         assign load[gi] = en & adv[gi];
         if (gi == 0) begin : g_head
            assign src_data[gi]  = d;
            assign src_valid[gi] = in_valid;
         end else begin : g_body
            assign src_data[gi]  = data_reg[gi-1];
            assign src_valid[gi] = valid_reg[gi-1];
         end
      end
   endgenerate

   always_comb begin
      count_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_next[i] = load[i] ? src_valid[i] : valid_reg[i];
         data_next[i]  = load[i] ? src_data[i]  : data_reg[i];
      end
      for (int i = 0; i < DEPTH; i++) begin
         count_next = count_next + CW'(valid_next[i]);
      end
   end

   // Flush shares the reset path so both leave the chain in the same known state.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_reg[i] <= RESET_VAL;
         end
         valid_reg <= '0;
         count_reg <= '0;
      end else begin
         data_reg  <= data_next;
         valid_reg <= valid_next;
         count_reg <= count_next;
      end
   end

   assign in_ready  = en & adv[0];
   assign q         = data_reg[DEPTH-1];
   assign out_valid = valid_reg[DEPTH-1];
   assign count     = count_reg;

endmodule

// File: tb/tb_pipe_en_r.sv
// Directed bench for pipe_en_r: rigid, elastic and non-zero reset-value instances share one stimulus bus.
module tb_pipe_en_r;

   logic       clk = 1'b0;
   logic       reset, en, flush, in_valid, out_ready;
   logic [7:0] d;

   logic       r_in_ready, r_out_valid;
   logic [7:0] r_q;
   logic [1:0] r_count;
   logic       e_in_ready, e_out_valid;
   logic [7:0] e_q;
   logic [1:0] e_count;
   logic       v_in_ready, v_out_valid;
   logic [7:0] v_q;
   logic [1:0] v_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_en_r #(.WIDTH(8), .DEPTH(3), .MODE(0), .RESET_VAL(8'h00)) u_rigid (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
      .in_ready(r_in_ready), .q(r_q), .out_valid(r_out_valid), .out_ready(out_ready), .count(r_count));

   pipe_en_r #(.WIDTH(8), .DEPTH(3), .MODE(1), .RESET_VAL(8'h00)) u_elastic (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
      .in_ready(e_in_ready), .q(e_q), .out_valid(e_out_valid), .out_ready(out_ready), .count(e_count));

   pipe_en_r #(.WIDTH(8), .DEPTH(3), .MODE(0), .RESET_VAL(8'h5A)) u_rv (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
      .in_ready(v_in_ready), .q(v_q), .out_valid(v_out_valid), .out_ready(out_ready), .count(v_count));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; en = 1'b0; in_valid = 1'b0; d = 8'h00; out_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h33; in_valid = 1'b1; out_ready = 1'b0;
      step();
      step();
      $display("test_reset: two edges with reset=1, d=33 in_valid=1");
      checks++; if (r_q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", r_q); end
      checks++; if (r_out_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b exp=0", r_out_valid); end
      checks++; if (r_count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", r_count); end
      checks++; if (e_count !== 2'd0 || e_out_valid !== 1'b0) begin failures++; $display("FAIL reset_elastic got count=%0d ov=%b exp 0/0", e_count, e_out_valid); end
      checks++; if (v_q !== 8'h5A) begin failures++; $display("FAIL reset_val_q got=%h exp=5a", v_q); end
      checks++; if (v_out_valid !== 1'b0 || v_count !== 2'd0) begin failures++; $display("FAIL reset_val_state got ov=%b count=%0d exp 0/0", v_out_valid, v_count); end
      reset = 1'b0;
   endtask

   task automatic test_rigid_shift();
      logic [7:0] exp_q  [6];
      logic       exp_ov [6];
      logic [1:0] exp_cnt[6];
      logic [7:0] din    [6];
      logic       dv     [6];
      exp_q   = '{8'h00, 8'h00, 8'hCC, 8'hAF, 8'h55, 8'h00};
      exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
      din     = '{8'hCC, 8'hAF, 8'h55, 8'h00, 8'h00, 8'h00};
      dv      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d = din[i]; in_valid = dv[i];
         #1;
         checks++; if (r_in_ready !== 1'b1) begin failures++; $display("FAIL rigid_in_ready edge%0d got=%b exp=1", i+1, r_in_ready); end
         step();
         $display("test_rigid_shift: edge%0d in=%h/%b q=%h ov=%b count=%0d", i+1, din[i], dv[i], r_q, r_out_valid, r_count);
         checks++; if (r_out_valid !== exp_ov[i]) begin failures++; $display("FAIL rigid_ov edge%0d got=%b exp=%b", i+1, r_out_valid, exp_ov[i]); end
         if (exp_ov[i]) begin
            checks++; if (r_q !== exp_q[i]) begin failures++; $display("FAIL rigid_q edge%0d got=%h exp=%h", i+1, r_q, exp_q[i]); end
         end
         checks++; if (r_count !== exp_cnt[i]) begin failures++; $display("FAIL rigid_count edge%0d got=%0d exp=%0d", i+1, r_count, exp_cnt[i]); end
      end
   endtask

   task automatic test_rigid_stall();
      do_reset();
      en = 1'b1; in_valid = 1'b1;
      d = 8'hCC; step();
      d = 8'hAF; step();
      en = 1'b0; d = 8'hEE;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (r_in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", r_in_ready); end
         step();
         $display("test_rigid_stall: stalled edge%0d q=%h ov=%b count=%0d", i+1, r_q, r_out_valid, r_count);
         checks++; if (r_count !== 2'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", r_count); end
         checks++; if (r_out_valid !== 1'b0 || r_q !== 8'h00) begin failures++; $display("FAIL stall_out got ov=%b q=%h exp 0/00", r_out_valid, r_q); end
      end
      en = 1'b1; d = 8'h55; step();
      checks++; if (r_q !== 8'hCC || r_out_valid !== 1'b1 || r_count !== 2'd3) begin failures++; $display("FAIL resume1 got q=%h ov=%b count=%0d exp cc/1/3", r_q, r_out_valid, r_count); end
      in_valid = 1'b0; step();
      checks++; if (r_q !== 8'hAF || r_out_valid !== 1'b1 || r_count !== 2'd2) begin failures++; $display("FAIL resume2 got q=%h ov=%b count=%0d exp af/1/2", r_q, r_out_valid, r_count); end
      step();
      checks++; if (r_q !== 8'h55 || r_out_valid !== 1'b1 || r_count !== 2'd1) begin failures++; $display("FAIL resume3 got q=%h ov=%b count=%0d exp 55/1/1", r_q, r_out_valid, r_count); end
   endtask

   task automatic test_elastic_backpressure();
      logic [7:0] pops[3];
      logic [1:0] pcnt[3];
      pops = '{8'hAF, 8'h55, 8'h77};
      pcnt = '{2'd3, 2'd2, 2'd1};
      do_reset();
      en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
      d = 8'hCC; step();
      d = 8'hAF; step();
      d = 8'h55; step();
      $display("test_elastic: filled q=%h count=%0d", e_q, e_count);
      checks++; if (e_count !== 2'd3) begin failures++; $display("FAIL el_full_count got=%0d exp=3", e_count); end
      d = 8'h77; #1;
      checks++; if (e_in_ready !== 1'b0) begin failures++; $display("FAIL el_full_in_ready got=%b exp=0", e_in_ready); end
      step();
      checks++; if (e_q !== 8'hCC || e_count !== 2'd3) begin failures++; $display("FAIL el_hold got q=%h count=%0d exp cc/3", e_q, e_count); end
      out_ready = 1'b1; #1;
      checks++; if (e_in_ready !== 1'b1) begin failures++; $display("FAIL el_pop_in_ready got=%b exp=1", e_in_ready); end
      checks++; if (e_q !== 8'hCC || e_out_valid !== 1'b1) begin failures++; $display("FAIL el_pop0 got q=%h ov=%b exp cc/1", e_q, e_out_valid); end
      step();
      $display("test_elastic: popped cc, pushed 77");
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         $display("test_elastic: pop%0d q=%h ov=%b count=%0d", i+1, e_q, e_out_valid, e_count);
         checks++; if (e_q !== pops[i] || e_out_valid !== 1'b1) begin failures++; $display("FAIL el_pop%0d got q=%h ov=%b exp %h/1", i+1, e_q, e_out_valid, pops[i]); end
         checks++; if (e_count !== pcnt[i]) begin failures++; $display("FAIL el_pop_count%0d got=%0d exp=%0d", i+1, e_count, pcnt[i]); end
         step();
      end
      checks++; if (e_out_valid !== 1'b0 || e_count !== 2'd0) begin failures++; $display("FAIL el_drained got ov=%b count=%0d exp 0/0", e_out_valid, e_count); end
   endtask

   task automatic test_elastic_flush();
      do_reset();
      en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
      d = 8'h10; step();
      d = 8'h20; step();
      d = 8'h30; step();
      flush = 1'b1; d = 8'h99; step();
      flush = 1'b0; in_valid = 1'b0;
      $display("test_elastic_flush: after flush q=%h ov=%b count=%0d", e_q, e_out_valid, e_count);
      checks++; if (e_count !== 2'd0 || e_out_valid !== 1'b0 || e_q !== 8'h00) begin failures++; $display("FAIL flush_state got q=%h ov=%b count=%0d exp 00/0/0", e_q, e_out_valid, e_count); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (e_out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak edge%0d got ov=%b q=%h exp ov=0", i+1, e_out_valid, e_q); end
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      en = 1'b1; in_valid = 1'b1;
      d = 8'hCC; step();
      d = 8'hAF; step();
      d = 8'h55; step();
      d = 8'h11; reset = 1'b1;
      #2;
      checks++; if (r_q !== 8'hCC || r_count !== 2'd3) begin failures++; $display("FAIL reset_early got q=%h count=%0d exp cc/3", r_q, r_count); end
      step();
      $display("test_reset_midstream: after reset q=%h ov=%b count=%0d", r_q, r_out_valid, r_count);
      checks++; if (r_q !== 8'h00 || r_out_valid !== 1'b0 || r_count !== 2'd0) begin failures++; $display("FAIL reset_mid got q=%h ov=%b count=%0d exp 00/0/0", r_q, r_out_valid, r_count); end
      reset = 1'b0;
      d = 8'h22; step();
      d = 8'h33; step();
      d = 8'h44; step();
      checks++; if (r_count !== 2'd3 || r_q !== 8'h22) begin failures++; $display("FAIL refill got q=%h count=%0d exp 22/3", r_q, r_count); end
      en = 1'b0; reset = 1'b1; flush = 1'b1; step();
      $display("test_reset_midstream: reset+flush stalled q=%h count=%0d", r_q, r_count);
      checks++; if (r_q !== 8'h00 || r_out_valid !== 1'b0 || r_count !== 2'd0) begin failures++; $display("FAIL reset_flush got q=%h ov=%b count=%0d exp 00/0/0", r_q, r_out_valid, r_count); end
      checks++; if (v_q !== 8'h5A || e_count !== 2'd0) begin failures++; $display("FAIL reset_flush_others got vq=%h ecount=%0d exp 5a/0", v_q, e_count); end
      reset = 1'b0; flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; d = 8'h00; out_ready = 1'b0;
      test_reset();
      test_rigid_shift();
      test_rigid_stall();
      test_elastic_backpressure();
      test_elastic_flush();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
